// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave front end for a 64 x 16-bit configuration
// register bank. All SPI pins are oversampled in the clk domain. Write frames
// update the bank. Read frames drive index into an external mux, capture
// rd_data and shift it back out on miso, MSB first.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [63:0][15:0] regs,
  output logic [5:0]       index,
  input  logic [15:0]      rd_data,
  output logic             wr_strobe,
  output logic [5:0]       wr_addr,
  output logic             frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, FLUSH} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  logic [3:0]  bit_cnt;
  logic [14:0] shift_in;
  logic [5:0]  cur_addr;
  logic [15:0] rd_shift;
  logic        rd_cap;
  logic        miso_q;

  logic        cmd_done, do_write, abort;
  logic        cmd_wr;
  logic [5:0]  cmd_addr;
  logic [15:0] data_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // On the 8th command bit the current mosi sample is address bit 0; the seven
  // earlier bits sit in shift_in[6:0] as W, reserved, addr[5:1].
  assign cmd_wr    = shift_in[6];
  assign cmd_addr  = {shift_in[4:0], mosi_s};
  assign data_word = {shift_in, mosi_s};

  assign miso_oe = (state == RDATA);
  assign miso    = miso_oe & miso_q;

  // Synchronise SPI pins and keep one extra sample for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour; blocking here would
      // collapse the synchroniser chain into a single stage.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-1-1:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Arm frame detection only after a genuine idle-high cs_n has been seen, so a
  // frame already running when reset is released is never joined.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (fill[SYNC_STAGES] & cs_s);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state and per-cycle control decodes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    next_state = state;
    cmd_done   = 1'b0;
    do_write   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall && armed) next_state = CMD;
      end
      CMD: begin
        if (cs_rise) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd7) begin
          cmd_done   = 1'b1;
          next_state = cmd_wr ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (cs_rise) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd15) begin
          do_write   = 1'b1;
          next_state = FLUSH;
        end
      end
      RDATA: begin
        if (cs_rise) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else if (sclk_rise && bit_cnt == 4'd15) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        if (cs_rise) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: bit counting, shifting, register writes and read-back shifting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register bank is reset on purpose: downstream logic reads
      // regs directly and must see all-zero configuration after reset.
      regs      <= '0;
      index     <= '0;
      wr_addr   <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      shift_in  <= '0;
      cur_addr  <= '0;
      rd_shift  <= '0;
      rd_cap    <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      wr_strobe <= do_write;
      frame_err <= abort;
      rd_cap    <= 1'b0;

      if (next_state != state)
        bit_cnt <= '0;
      else if (sclk_rise && (state == CMD || state == WDATA || state == RDATA))
        bit_cnt <= bit_cnt + 4'd1;

      if (sclk_rise && (state == CMD || state == WDATA))
        shift_in <= {shift_in[13:0], mosi_s};

      if (cmd_done) begin
        cur_addr <= cmd_addr;
        if (!cmd_wr) begin
          index  <= cmd_addr;
          rd_cap <= 1'b1;
          miso_q <= 1'b0;
        end
      end

      // rd_data from the external mux settles one clk after index changes.
      if (rd_cap) begin
        rd_shift <= rd_data;
      end else if (state == RDATA && sclk_fall) begin
        miso_q   <= rd_shift[15];
        rd_shift <= {rd_shift[14:0], 1'b0};
      end

      if (do_write) begin
        regs[cur_addr] <= data_word;
        wr_addr        <= cur_addr;
      end
    end
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

SPI-slave configuration front end that owns the 64 x 16-bit register bank feeding `registerMux`. It deserialises host frames, writes the addressed register, and for read frames drives `index` into `registerMux`, captures its `out`, and shifts that value back to the host. All SPI pins are oversampled in the system clock domain; there is no second clock.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `cs_n`, `mosi` (2 or 3 supported)
- Register count 64, width 16, address width 6 are fixed (match `registerMux`).

Ports:
- `clk`  in  1  system clock; one clock for the whole block
- `rst_n`  in  1  reset, synchronous, active-low
- `sclk`  in  1  SPI clock from host, async
- `cs_n`  in  1  SPI chip select, active-low, async
- `mosi`  in  1  SPI data in, async
- `miso`  out  1  SPI data out
- `miso_oe`  out  1  high while a read frame's data phase is active
- `regs`  out  16 x [63:0]  register bank contents, to `registerMux.regs`
- `index`  out  6  read address, to `registerMux.index`
- `rd_data`  in  16  from `registerMux.out`
- `wr_strobe`  out  1  one-cycle pulse when a register is written
- `wr_addr`  out  6  address of last write, valid with `wr_strobe`
- `frame_err`  out  1  one-cycle pulse when a frame is aborted

## Operation
- SPI mode 0: host changes `mosi` on falling `sclk`, block samples on rising; block updates `miso` on falling `sclk`. MSB first.
- Frame = 24 bits while `cs_n` low: bit 23 `W` (1 = write, 0 = read), bit 22 reserved (ignored), bits 21:16 address, bits 15:0 data (write) or don't-care (read).
- Inputs pass through `SYNC_STAGES` flops; edges detected from last two synchronised `sclk` samples; `cs_n` fall/rise detected likewise.
- FSM states: IDLE, CMD, WDATA, RDATA, FLUSH.
- IDLE: on synchronised `cs_n` falling -> CMD, bit counter = 0.
- CMD: shift 8 bits. On 8th rising edge: latch W and address; W=1 -> WDATA; W=0 -> RDATA, drive `index` = address.
- WDATA: shift 16 bits. On 16th rising edge: `regs[addr]` <= data, `wr_strobe` = 1, `wr_addr` = addr, -> FLUSH.
- RDATA: one cycle after `index` is driven, capture `rd_data` into the shift register. `miso_oe` = 1. Each falling edge presents next bit, bit 15 on the first falling edge after the 8th command bit. After the 16th data bit's rising edge -> FLUSH.
- FLUSH: extra `sclk` edges are ignored, `miso` = 0; on `cs_n` rising -> IDLE.
- `cs_n` rising in CMD, WDATA or RDATA: abort, no register write, `frame_err` pulses one cycle, -> IDLE.
- `cs_n` rising in FLUSH: -> IDLE, no error.
- `miso` = 0 and `miso_oe` = 0 whenever not in RDATA.
- `index` holds its last value outside reads.

## Timing
- Reset (`rst_n` low at a `clk` edge): all 64 `regs` = 16'h0000, `index` = 0, `wr_addr` = 0, `miso` = 0, `miso_oe` = 0, `wr_strobe` = 0, `frame_err` = 0, FSM = IDLE, synchronisers cleared to idle levels (`cs_n`=1, `sclk`=0). A reset mid-frame discards the frame. After reset release the block waits for a fresh `cs_n` falling edge; a frame already in progress is not joined.
- `sclk` period must be >= 8 `clk` periods, and each phase >= 4 `clk`. `cs_n` setup to first `sclk` rising and hold after last `sclk` falling must each be >= 4 `clk`.
- Write latency: `regs[addr]` and `wr_strobe` update at the edge `SYNC_STAGES`+1 `clk` after the 24th `sclk` rising edge reaches the pin.
- Read: `index` valid `SYNC_STAGES`+1 `clk` after the 8th rising edge. `rd_data` is sampled exactly one `clk` later, well before the next falling edge at the minimum `sclk` period.
- A write to the address being read in the same frame cannot occur; frames are strictly serial.
- Back-to-back frames: `cs_n` high for >= 4 `clk` is sufficient.

## Test plan
- Write 0xBEEF to address 5 -> `regs[5]`=0xBEEF, single `wr_strobe` with `wr_addr`=5, all other regs 0.
- Read address 5 after that write -> `index`=5, `miso` shows 1011_1110_1110_1111 MSB first, `miso_oe` high for exactly 16 bits.
- Write 0x0001 to addr 0 and 0x8000 to addr 63, read both back -> correct values, no aliasing.
- Drop `cs_n` after 20 bits of a write of 0x1234 to addr 9 -> `regs[9]` unchanged, one `frame_err` pulse, next full frame works.
- Assert `rst_n` low mid-read after writing 0xA5A5 to addr 3 -> all regs 0, `miso`/`miso_oe` 0 next cycle, later read of addr 3 returns 0x0000.
- Send 26 `sclk` cycles in one write frame -> only one write and one `wr_strobe`, extra bits ignored, no `frame_err`.
